rs_queue: RTL and testbench
===========================

RS_QUEUE -- requirements
Module: rs_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 144: payload width of one entry.
REQ-002 SHALL have parameter TAG_WIDTH, default 32: width of the program-order tag per entry.
REQ-003 SHALL have parameter ADDR_WIDTH, default 3: DEPTH = 2^ADDR_WIDTH entries.
REQ-004 SHALL have parameter WR_PORTS, default 4 (legal 1..4): maximum pushes per cycle.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port push_cnt, input, 3: number of entries offered this cycle (0..WR_PORTS).
REQ-008 SHALL have port push_data, input, WR_PORTS*DATA_WIDTH: slot i at [i*DATA_WIDTH +: DATA_WIDTH]; slot 0 is the oldest.
REQ-009 SHALL have port push_tag, input, WR_PORTS*TAG_WIDTH: per-slot tag, same slot order as push_data.
REQ-010 SHALL have port push_rdy, output, 1: high when free >= push_cnt.
REQ-011 SHALL have port pop, input, 1: consume the head entry.
REQ-012 SHALL have port flush, input, 1: branch mispredict, one-cycle pulse.
REQ-013 SHALL have port flush_tag, input, TAG_WIDTH: squash entries with tag >= flush_tag.
REQ-014 SHALL have ports head_valid (1), head_data (DATA_WIDTH) and head_tag (TAG_WIDTH), outputs: the oldest entry; data and tag read 0 when empty.
REQ-015 SHALL have ports count (ADDR_WIDTH+1) and free (ADDR_WIDTH+1), outputs: occupancy and DEPTH-count.
REQ-016 SHALL have ports empty and full, outputs, 1 each.

Function
REQ-017 SHALL be a circular FIFO with rd_ptr and wr_ptr, each ADDR_WIDTH wide, wrapping modulo DEPTH.
REQ-018 SHALL accept a push group only as a whole: push_cnt>0, push_rdy=1 and no flush; then write slots 0..push_cnt-1 to wr_ptr..wr_ptr+push_cnt-1 (mod DEPTH) and advance wr_ptr by push_cnt.
REQ-019 SHALL, when push_cnt > free, write nothing and leave the pointers unchanged; no partial push.
REQ-020 SHALL treat push_cnt > WR_PORTS as push_cnt = 0.
REQ-021 SHALL ignore pop while empty; otherwise advance rd_ptr by 1.
REQ-022 SHALL present head outputs combinationally from storage at rd_ptr: zero-cycle read latency; a pushed entry is visible at the head the cycle after the push edge.
REQ-023 SHALL allow push and pop in the same cycle: count changes by push_cnt-1. push_rdy uses the pre-pop free value; no same-cycle credit.
REQ-024 SHALL, on flush, compute K = number of consecutive entries from the head with tag < flush_tag (unsigned compare), and set wr_ptr = rd_ptr+K (pre-pop rd_ptr).
REQ-025 SHALL, on flush, discard the same-cycle push group; the group is younger by construction.
REQ-026 SHALL, on flush with pop, still pop the head if head tag < flush_tag, giving count = K-1; otherwise count = 0.
REQ-027 SHALL set count = wr_ptr-rd_ptr (mod 2*DEPTH) with full = (count==DEPTH), and set empty = (count==0).
REQ-028 SHALL NOT clear squashed storage; those entries are unreachable.

Reset
REQ-029 SHALL, on rst_n low and independent of clk, set rd_ptr=0, wr_ptr=0 and count=0.
REQ-030 SHALL hold these values during reset: empty=1, full=0, free=DEPTH, push_rdy=1, head_valid=0, head_data=0, head_tag=0.
REQ-031 SHALL abort any in-flight push, pop or flush if reset asserts; no entry survives.

Configuration
REQ-032 SHALL honour macro RS_QUEUE_HWM_EN, which adds output hwm (ADDR_WIDTH+1): the peak count since reset.
REQ-033 SHALL, with RS_QUEUE_HWM_EN defined, update hwm each cycle to max(hwm, next count) and reset it to 0.
REQ-034 SHALL, without RS_QUEUE_HWM_EN, omit the hwm port and register, with no other behavioural difference.

Verification
REQ-035 SHALL cover: reset, push_cnt=3 with tags 5,6,7 -> next cycle count=3, head_tag=5, push_rdy=1.
REQ-036 SHALL cover: fill to count=6 (DEPTH 8), push_cnt=3 -> push_rdy=0, count stays 6; push_cnt=2 -> count=8, full=1.
REQ-037 SHALL cover: wrap case, rd_ptr=6, push 4 entries -> stored at indices 6,7,0,1; popping returns them in push order.
REQ-038 SHALL cover: queue tags 10..15, flush_tag=13 -> count=3, wr_ptr=rd_ptr+3; the next push lands after tag 12.
REQ-039 SHALL cover: flush_tag=13 with pop and push_cnt=2 in the same cycle -> tag 10 popped, count=2, pushed entries absent.
REQ-040 SHALL cover: rst_n low mid-cycle with count=5 -> empty=1 immediately without a clk edge; hwm=0 when RS_QUEUE_HWM_EN is defined.

Source files
------------

// File: rtl/rs_queue.sv
// rs_queue: multi-push, single-pop reservation-station queue.
// Entries carry a payload and a program-order tag. A branch mispredict
// flush keeps only the run of entries from the head whose tag is older
// than flush_tag. Squashed storage is left in place but becomes unreachable.
// Optional feature: define RS_QUEUE_HWM_EN to add the hwm (peak occupancy) output.
module rs_queue #(
    parameter int DATA_WIDTH = 144,
    parameter int TAG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int WR_PORTS   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [2:0]                     push_cnt,
    input  logic [WR_PORTS*DATA_WIDTH-1:0] push_data,
    input  logic [WR_PORTS*TAG_WIDTH-1:0]  push_tag,
    output logic                           push_rdy,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [TAG_WIDTH-1:0]           flush_tag,
    output logic                           head_valid,
    output logic [DATA_WIDTH-1:0]          head_data,
    output logic [TAG_WIDTH-1:0]           head_tag,
    output logic [ADDR_WIDTH:0]            count,
    output logic [ADDR_WIDTH:0]            free,
`ifdef RS_QUEUE_HWM_EN
    output logic [ADDR_WIDTH:0]            hwm,
`endif
    output logic                           empty,
    output logic                           full
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int EW    = (CW > 3) ? CW : 3;

    // Pointers carry one extra wrap bit so count = wr - rd distinguishes full from empty.
    logic [CW-1:0]         rd_ext;
    logic [CW-1:0]         wr_ext;
    logic [CW-1:0]         rd_next;
    logic [CW-1:0]         wr_next;
    logic [CW-1:0]         count_next;
    logic [CW-1:0]         flush_k;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [2:0]            eff_cnt;
    logic                  push_fire;
    logic                  pop_fire;

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [TAG_WIDTH-1:0]  mem_tag  [DEPTH];

    assign rd_ptr = rd_ext[ADDR_WIDTH-1:0];
    assign wr_ptr = wr_ext[ADDR_WIDTH-1:0];

    assign count = wr_ext - rd_ext;
    assign free  = CW'(DEPTH) - count;
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Out-of-range group sizes behave as an idle cycle.
    assign eff_cnt   = (int'(push_cnt) > WR_PORTS) ? 3'd0 : push_cnt;
    assign push_rdy  = (EW'(free) >= EW'(eff_cnt));
    assign push_fire = (eff_cnt != 3'd0) && push_rdy && !flush;
    assign pop_fire  = pop && !empty;

    assign head_valid = !empty;
    assign head_data  = empty ? '0 : mem_data[rd_ptr];
    assign head_tag   = empty ? '0 : mem_tag[rd_ptr];

    // Length of the run of surviving (older-than-flush_tag) entries from the head.
    always_comb begin
        logic                  run;
        logic [ADDR_WIDTH-1:0] idx;
        flush_k = '0;
        run     = 1'b1;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + ADDR_WIDTH'(i);
            if (run && (CW'(i) < count) && (mem_tag[idx] < flush_tag)) begin
                flush_k = flush_k + 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end

    // Next pointer values; a flush overrides the push group and trims the tail.
    always_comb begin
        rd_next = rd_ext;
        wr_next = wr_ext;
        if (flush) begin
            wr_next = rd_ext + flush_k;
            if (pop && (flush_k != '0)) begin
                rd_next = rd_ext + 1'b1;
            end
        end else begin
            if (push_fire) begin
                wr_next = wr_ext + CW'(eff_cnt);
            end
            if (pop_fire) begin
                rd_next = rd_ext + 1'b1;
            end
        end
        count_next = wr_next - rd_next;
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ext <= '0;
            wr_ext <= '0;
        end else begin
            rd_ext <= rd_next;
            wr_ext <= wr_next;
        end
    end

    // Entry storage: write the accepted slots at consecutive addresses from wr_ptr.
    always_ff @(posedge clk) begin
        if (push_fire && rst_n) begin
            for (int i = 0; i < WR_PORTS; i++) begin
                if (3'(i) < eff_cnt) begin
                    mem_data[wr_ptr + ADDR_WIDTH'(i)] <= push_data[i*DATA_WIDTH +: DATA_WIDTH];
                    mem_tag[wr_ptr + ADDR_WIDTH'(i)]  <= push_tag[i*TAG_WIDTH +: TAG_WIDTH];
                end
            end
        end
    end

`ifdef RS_QUEUE_HWM_EN
    // Peak occupancy since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm <= '0;
        end else if (count_next > hwm) begin
            hwm <= count_next;
        end
    end
`endif

endmodule

// File: tb/tb_rs_queue.sv
// tb_rs_queue: randomized and directed stimulus for rs_queue, checked by a
// scoreboard against a queue-based reference model of the entry list.
module tb_rs_queue;

    localparam int DW    = 144;
    localparam int TW    = 32;
    localparam int AW    = 3;
    localparam int WP    = 4;
    localparam int DEPTH = 8;

    logic              clk;
    logic              rst_n;
    logic [2:0]        push_cnt;
    logic [WP*DW-1:0]  push_data;
    logic [WP*TW-1:0]  push_tag;
    logic              push_rdy;
    logic              pop;
    logic              flush;
    logic [TW-1:0]     flush_tag;
    logic              head_valid;
    logic [DW-1:0]     head_data;
    logic [TW-1:0]     head_tag;
    logic [AW:0]       count;
    logic [AW:0]       free;
    logic              empty;
    logic              full;
`ifdef RS_QUEUE_HWM_EN
    logic [AW:0]       hwm;
`endif

    rs_queue #(
        .DATA_WIDTH(DW),
        .TAG_WIDTH (TW),
        .ADDR_WIDTH(AW),
        .WR_PORTS  (WP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .push_tag  (push_tag),
        .push_rdy  (push_rdy),
        .pop       (pop),
        .flush     (flush),
        .flush_tag (flush_tag),
        .head_valid(head_valid),
        .head_data (head_data),
        .head_tag  (head_tag),
        .count     (count),
        .free      (free),
`ifdef RS_QUEUE_HWM_EN
        .hwm       (hwm),
`endif
        .empty     (empty),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            cnt;
        int            fr;
        bit            hv;
        bit            rdy;
        bit            fl;
        bit            em;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        int            hw;
    } exp_t;

    exp_t          exp_q[$];
    logic [TW-1:0] m_tag[$];
    logic [DW-1:0] m_data[$];
    int            m_hwm;
    int            vectors;
    int            miscompares;

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // Expected observable outputs for the current model contents and held push_cnt.
    function automatic exp_t model_exp(int held_cnt);
        exp_t e;
        int   eff;
        eff    = (held_cnt > WP) ? 0 : held_cnt;
        e.cnt  = m_tag.size();
        e.fr   = DEPTH - e.cnt;
        e.hv   = (e.cnt != 0);
        e.rdy  = (eff <= e.fr);
        e.fl   = (e.cnt == DEPTH);
        e.em   = (e.cnt == 0);
        e.tag  = (e.cnt != 0) ? m_tag[0] : '0;
        e.data = (e.cnt != 0) ? m_data[0] : '0;
        e.hw   = m_hwm;
        return e;
    endfunction

    task automatic cmp(string name, logic [DW-1:0] act, logic [DW-1:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    task automatic check_obs(exp_t e);
        vectors++;
        cmp("count",      DW'(count),      DW'(e.cnt));
        cmp("free",       DW'(free),       DW'(e.fr));
        cmp("head_valid", DW'(head_valid), DW'(e.hv));
        cmp("push_rdy",   DW'(push_rdy),   DW'(e.rdy));
        cmp("full",       DW'(full),       DW'(e.fl));
        cmp("empty",      DW'(empty),      DW'(e.em));
        cmp("head_tag",   DW'(head_tag),   DW'(e.tag));
        cmp("head_data",  head_data,       e.data);
`ifdef RS_QUEUE_HWM_EN
        cmp("hwm",        DW'(hwm),        DW'(e.hw));
`endif
    endtask

    // Monitor: one expected observation per clock, sampled after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_obs(e);
            end
        end
    end

    // One cycle of stimulus; the model is updated and the expected result queued.
    task automatic cyc(int cnt, int t0, bit rnd_tags, bit p, bit f, int ft);
        logic [TW-1:0] tags [WP];
        logic [DW-1:0] datas[WP];
        int            eff;
        int            size;
        int            k;
        bit            accept;
        @(negedge clk);
        for (int i = 0; i < WP; i++) begin
            tags[i]  = rnd_tags ? TW'($urandom_range(0, 40)) : TW'(t0 + i);
            datas[i] = rand_data();
            push_tag[i*TW +: TW]  = tags[i];
            push_data[i*DW +: DW] = datas[i];
        end
        push_cnt  = 3'(cnt);
        pop       = p;
        flush     = f;
        flush_tag = TW'(ft);

        eff  = (cnt > WP) ? 0 : cnt;
        size = m_tag.size();
        if (f) begin
            k = 0;
            while (k < size && m_tag[k] < TW'(ft)) k++;
            while (m_tag.size() > k) begin
                void'(m_tag.pop_back());
                void'(m_data.pop_back());
            end
            if (p && k > 0) begin
                void'(m_tag.pop_front());
                void'(m_data.pop_front());
            end
        end else begin
            accept = (eff > 0) && (eff <= DEPTH - size);
            if (p && size > 0) begin
                void'(m_tag.pop_front());
                void'(m_data.pop_front());
            end
            if (accept) begin
                for (int i = 0; i < eff; i++) begin
                    m_tag.push_back(tags[i]);
                    m_data.push_back(datas[i]);
                end
            end
        end
        if (m_tag.size() > m_hwm) m_hwm = m_tag.size();
        exp_q.push_back(model_exp(cnt));
    endtask

    task automatic idle();
        cyc(0, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 1'b0, 1'b1, 1'b0, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_hwm       = 0;
        rst_n       = 1'b0;
        push_cnt    = '0;
        push_data   = '0;
        push_tag    = '0;
        pop         = 1'b0;
        flush       = 1'b0;
        flush_tag   = '0;

        // Reset values.
        #12;
        check_obs(model_exp(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Group of three, then fill to six and test group rejection and fill to full.
        cyc(3, 5, 1'b0, 1'b0, 1'b0, 0);
        cyc(3, 8, 1'b0, 1'b0, 1'b0, 0);
        cyc(3, 11, 1'b0, 1'b0, 1'b0, 0);
        cyc(2, 14, 1'b0, 1'b0, 1'b0, 0);
        cyc(1, 16, 1'b0, 1'b0, 1'b0, 0);
        cyc(5, 16, 1'b0, 1'b0, 1'b0, 0);
        drain();

        // Wrap: move rd_ptr to 6, then push four entries across the end.
        cyc(3, 30, 1'b0, 1'b0, 1'b0, 0);
        cyc(3, 33, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1'b0, 1'b1, 1'b0, 0);
        cyc(4, 20, 1'b0, 1'b0, 1'b0, 0);
        drain();

        // Flush keeps tags 10..12, next push follows tag 12.
        cyc(4, 10, 1'b0, 1'b0, 1'b0, 0);
        cyc(2, 14, 1'b0, 1'b0, 1'b0, 0);
        cyc(0, 0, 1'b0, 1'b0, 1'b1, 13);
        cyc(1, 50, 1'b0, 1'b0, 1'b0, 0);
        drain();

        // Flush with pop and a same-cycle push group.
        cyc(4, 10, 1'b0, 1'b0, 1'b0, 0);
        cyc(2, 14, 1'b0, 1'b0, 1'b0, 0);
        cyc(2, 60, 1'b0, 1'b1, 1'b1, 13);
        drain();

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            cyc($urandom_range(0, 7), 0, 1'b1, ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 15) == 0), $urandom_range(0, 40));
        end
        drain();

        // Asynchronous reset mid-cycle with five entries queued.
        cyc(3, 1, 1'b0, 1'b0, 1'b0, 0);
        cyc(2, 4, 1'b0, 1'b0, 1'b0, 0);
        idle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        m_tag.delete();
        m_data.delete();
        m_hwm = 0;
        check_obs(model_exp(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 200; n++) begin
            cyc($urandom_range(0, 5), 0, 1'b1, ($urandom_range(0, 1) == 0),
                ($urandom_range(0, 20) == 0), $urandom_range(0, 40));
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
